// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port synchronous RAM between fetch (I, read-only) and data (D, read/write) requesters.
// Latency: read 3 cycles req->rvalid, write 2 cycles occupancy; requests arriving while busy are held off, never dropped.
module ram_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

    state_t              state_q;
    logic                owner_is_d_q;
    logic                last_is_d_q;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;
    logic                i_rvalid_q;
    logic                d_rvalid_q;
    logic                grant_to_data;

    // On contention: D always wins in fixed mode, otherwise the port that did not go last.
    always_comb begin
        grant_to_data = d_req && (!i_req || !RR_EN || !last_is_d_q);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            owner_is_d_q <= 1'b0;
            last_is_d_q  <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_rvalid_q   <= 1'b0;
            d_rvalid_q   <= 1'b0;
        end else begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        owner_is_d_q <= grant_to_data;
                        last_is_d_q  <= grant_to_data;
                        addr_q       <= grant_to_data ? d_addr : i_addr;
                        we_q         <= grant_to_data && d_we;
                        if (grant_to_data) begin
                            wdata_q <= d_wdata;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= we_q ? IDLE : RD_WAIT;
                end
                RD_WAIT: begin
                    if (owner_is_d_q) begin
                        d_rdata_q  <= ram_dout;
                        d_rvalid_q <= 1'b1;
                    end else begin
                        i_rdata_q  <= ram_dout;
                        i_rvalid_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM strobes decode from state so an asynchronous reset kills an in-flight write at once.
    assign ram_read  = (state_q == ISSUE) && !we_q;
    assign ram_write = (state_q == ISSUE) && we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
    assign i_gnt     = (state_q == ISSUE) && !owner_is_d_q;
    assign d_gnt     = (state_q == ISSUE) && owner_is_d_q;
    assign i_rvalid  = i_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: random I/D traffic against a transaction-level model, plus reset and fixed-priority cases.
module tb_ram_port_arbiter;
    localparam int AW = 9;
    localparam int DW = 32;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic          Resetn;
    logic          i_req, i_gnt, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          ram_read, ram_write, busy;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    // Second instance in fixed-priority mode with its own reset.
    logic          f_rst_n, f_i_req, f_i_gnt, f_i_rvalid, f_d_req, f_d_we, f_d_gnt, f_d_rvalid;
    logic [AW-1:0] f_i_addr, f_d_addr, f_ram_addr;
    logic [DW-1:0] f_i_rdata, f_d_wdata, f_d_rdata, f_ram_din;
    logic [DW-1:0] f_ram_dout = '0;
    logic          f_ram_read, f_ram_write, f_busy;

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b1)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR_EN(1'b0)) u_fix (
        .Clock(Clock), .Resetn(f_rst_n),
        .i_req(f_i_req), .i_addr(f_i_addr), .i_gnt(f_i_gnt), .i_rvalid(f_i_rvalid), .i_rdata(f_i_rdata),
        .d_req(f_d_req), .d_we(f_d_we), .d_addr(f_d_addr), .d_wdata(f_d_wdata),
        .d_gnt(f_d_gnt), .d_rvalid(f_d_rvalid), .d_rdata(f_d_rdata),
        .ram_read(f_ram_read), .ram_write(f_ram_write), .ram_addr(f_ram_addr), .ram_din(f_ram_din),
        .ram_dout(f_ram_dout), .busy(f_busy)
    );

    function automatic logic [DW-1:0] pattern(input int a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Synchronous RAM: write and read on the rising edge, DataOut valid the following cycle.
    logic          load_en;
    logic [DW-1:0] mem [512];
    always @(posedge Clock) begin
        if (load_en) begin
            for (int k = 0; k < 512; k++) mem[k] <= pattern(k);
        end else begin
            if (ram_write) mem[ram_addr] <= ram_din;
            if (ram_read)  ram_dout <= mem[ram_addr];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Transaction-level model: one access in flight; accepted at an edge, it owns the RAM for
    // 3 edges (read) or 2 edges (write); read data is whatever the model memory holds at acceptance.
    typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] data;} txn_t;
    txn_t          iq[$];
    txn_t          dq[$];
    logic [DW-1:0] ref_mem [512];
    int            cyc, acc_edge, free_edge;
    bit            acc_d, acc_we, last_d, i_done, d_done;
    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_data, exp_i_rdata, exp_d_rdata;

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 9'h000;
            1:       return 9'h1FF;
            2:       return 9'h010;
            default: return AW'($urandom_range(0, 15));
        endcase
    endfunction

    task automatic check_cycle(input int c);
        bit issue, rdv;
        issue = (c == acc_edge);
        rdv   = (c == acc_edge + 2) && !acc_we;
        if (rdv && acc_d)  exp_d_rdata = acc_data;
        if (rdv && !acc_d) exp_i_rdata = acc_data;
        check("i_gnt", 32'(i_gnt), 32'(issue && !acc_d));
        check("d_gnt", 32'(d_gnt), 32'(issue && acc_d));
        check("ram_read", 32'(ram_read), 32'(issue && !acc_we));
        check("ram_write", 32'(ram_write), 32'(issue && acc_we));
        check("busy", 32'(busy), 32'(issue || ((c == acc_edge + 1) && !acc_we)));
        check("i_rvalid", 32'(i_rvalid), 32'(rdv && !acc_d));
        check("d_rvalid", 32'(d_rvalid), 32'(rdv && acc_d));
        check("i_rdata", i_rdata, exp_i_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        if (issue) begin
            check("ram_addr", 32'(ram_addr), 32'(acc_addr));
            if (acc_we) check("ram_din", ram_din, acc_data);
        end
    endtask

    task automatic drive_agents(input int c);
        txn_t t;
        if (i_done || !i_req) begin
            i_done = 1'b0;
            if (c >= 9 && iq.size() > 0) begin
                t = iq.pop_front();
                i_req = 1'b1; i_addr = t.addr;
            end else if (c >= 9 && $urandom_range(0, 2) != 0) begin
                i_req = 1'b1; i_addr = pick_addr();
            end else begin
                i_req = 1'b0;
            end
        end
        if (d_done || !d_req) begin
            d_done = 1'b0;
            if (dq.size() > 0) begin
                t = dq.pop_front();
                d_req = 1'b1; d_we = t.we; d_addr = t.addr; d_wdata = t.data;
            end else if ($urandom_range(0, 2) != 0) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = pick_addr(); d_wdata = $urandom;
            end else begin
                d_req = 1'b0;
            end
        end
    endtask

    task automatic model_edge();
        bit win_d;
        cyc++;
        if (cyc >= free_edge && (i_req || d_req)) begin
            if (i_req && d_req) win_d = !last_d;
            else                win_d = d_req;
            acc_edge = cyc;
            acc_d    = win_d;
            acc_we   = win_d && d_we;
            acc_addr = win_d ? d_addr : i_addr;
            if (acc_we) ref_mem[acc_addr] = d_wdata;
            acc_data  = ref_mem[acc_addr];
            free_edge = cyc + (acc_we ? 2 : 3);
            last_d    = win_d;
            if (win_d) d_done = 1'b1;
            else       i_done = 1'b1;
        end
    endtask

    initial begin
        for (int k = 0; k < 512; k++) ref_mem[k] = pattern(k);
        Resetn = 1'b0; load_en = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        f_rst_n = 1'b0; f_i_req = 0; f_i_addr = 9'h055; f_d_req = 0; f_d_we = 0; f_d_addr = 9'h0AA; f_d_wdata = '0;
        repeat (3) @(negedge Clock);
        load_en = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'({i_gnt, d_gnt}), 0);
        check("rst_rdata", i_rdata | d_rdata, 0);

        // Reset arriving while a write is in ISSUE abandons it.
        Resetn = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 9'd5; d_wdata = 32'h0000_DEAD;
        @(posedge Clock); #1;
        check("wr_issue_ram_write", 32'(ram_write), 1);
        check("wr_issue_d_gnt", 32'(d_gnt), 1);
        #1 Resetn = 1'b0;
        #1;
        check("rst_ram_write_drop", 32'(ram_write), 0);
        check("rst_ram_read", 32'(ram_read), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_busy_drop", 32'(busy), 0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 0);
        d_req = 1'b0; d_we = 1'b0;
        @(posedge Clock); @(posedge Clock); #1;
        check("ram5_untouched", mem[5], ref_mem[5]);

        dq.push_back('{1'b1, 9'h010, 32'hCAFE_F00D});
        dq.push_back('{1'b0, 9'h010, 32'h0});
        dq.push_back('{1'b1, 9'h1FF, 32'hFFFF_FFFF});
        iq.push_back('{1'b0, 9'h000, 32'h0});
        iq.push_back('{1'b0, 9'h1FF, 32'h0});
        iq.push_back('{1'b0, 9'h000, 32'h0});
        cyc = 0; acc_edge = -100; free_edge = 0; last_d = 1'b1;
        i_done = 0; d_done = 0; acc_d = 0; acc_we = 0; acc_addr = '0; acc_data = '0;
        exp_i_rdata = '0; exp_d_rdata = '0;

        @(negedge Clock);
        Resetn = 1'b1;
        for (int n = 0; n < 400; n++) begin
            check_cycle(cyc);
            drive_agents(cyc);
            @(posedge Clock);
            model_edge();
            @(negedge Clock);
        end
        i_req = 1'b0; d_req = 1'b0;

        // Fixed priority: D reads back-to-back starve I until D drops its request.
        f_d_req = 1'b1; f_i_req = 1'b1;
        @(negedge Clock);
        f_rst_n = 1'b1;
        for (int fc = 0; fc <= 16; fc++) begin
            bit dacc, iacc, dacc1, iacc1, dacc2, iacc2;
            dacc  = (fc >= 1 && fc <= 10 && fc % 3 == 1);
            iacc  = (fc == 13);
            dacc1 = (fc >= 2 && fc <= 11 && (fc - 1) % 3 == 1);
            iacc1 = (fc == 14);
            dacc2 = (fc >= 3 && fc <= 12 && (fc - 2) % 3 == 1);
            iacc2 = (fc == 15);
            check("fix_d_gnt", 32'(f_d_gnt), 32'(dacc));
            check("fix_i_gnt", 32'(f_i_gnt), 32'(iacc));
            check("fix_busy", 32'(f_busy), 32'(dacc || iacc || dacc1 || iacc1));
            check("fix_d_rvalid", 32'(f_d_rvalid), 32'(dacc2));
            check("fix_i_rvalid", 32'(f_i_rvalid), 32'(iacc2));
            check("fix_ram_read", 32'(f_ram_read), 32'(dacc || iacc));
            check("fix_ram_write", 32'(f_ram_write), 0);
            if (dacc) check("fix_ram_addr_d", 32'(f_ram_addr), 32'h0AA);
            if (iacc) check("fix_ram_addr_i", 32'(f_ram_addr), 32'h055);
            if (fc == 10) f_d_req = 1'b0;
            if (fc == 13) f_i_req = 1'b0;
            @(posedge Clock);
            @(negedge Clock);
        end
        check("fix_rdata", f_i_rdata | f_d_rdata | f_ram_din, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
